// File: rtl/trap_ctrl.sv
// trap_ctrl: trap / interrupt entry sequencer.
//   Arbitrates synchronous traps (illegal instruction, trap instruction) and
//   masked, level-sensitive external interrupts. A take walks IDLE -> ENTER -> HOLD.
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   psr_in[15:0]   : current PSR, bit1 = IM (masks external interrupts)
//   illegal_insn   : decoder flags an illegal instruction
//   sw_trap        : decoder flags a trap instruction
//   rfi_in         : decoder requests return-from-interrupt
//   insn_boundary  : instruction boundary (pc_wen cycle)
//   irq[N_IRQ-1:0] : external interrupt levels
//   mask_wen/mask_wdata : interrupt enable mask write port
//   trap           : one-cycle trap-entry pulse (ENTER)
//   rfi            : one-cycle return pulse
//   stall          : freeze PC update / issue
//   cause[3:0]     : 0 none, 1 illegal, 2 sw_trap, 8+i irq[i]
//   irq_ack        : one-hot acknowledge of the interrupt taken (ENTER)
//   irq_mask       : current enable mask
module trap_ctrl #(
  parameter int N_IRQ = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      psr_in,
  input  logic             illegal_insn,
  input  logic             sw_trap,
  input  logic             rfi_in,
  input  logic             insn_boundary,
  input  logic [N_IRQ-1:0] irq,
  input  logic             mask_wen,
  input  logic [N_IRQ-1:0] mask_wdata,
  output logic             trap,
  output logic             rfi,
  output logic             stall,
  output logic [3:0]       cause,
  output logic [N_IRQ-1:0] irq_ack,
  output logic [N_IRQ-1:0] irq_mask
);

  typedef enum logic [1:0] {S_IDLE, S_ENTER, S_HOLD} state_t;

  state_t           r_state;
  logic [3:0]       r_cause;
  logic [N_IRQ-1:0] r_mask;
  logic             r_rfi_shadow;

  logic             w_idle;
  logic [N_IRQ-1:0] w_pend;
  logic             w_take_sync;
  logic             w_take_irq;
  logic [3:0]       w_irq_cause;
  logic             w_rfi;
  logic             w_unused_psr;

  // Only IM matters; other PSR bits are deliberately ignored.
  assign w_unused_psr = ^{psr_in[15:2], psr_in[0]};

  assign w_idle      = (r_state == S_IDLE);
  assign w_pend      = irq & r_mask;
  assign w_take_sync = w_idle & (illegal_insn | sw_trap);
  // The rfi shadow keeps an interrupt from slipping in before the restored PSR lands.
  assign w_take_irq  = w_idle & insn_boundary & ~psr_in[1] & (|w_pend)
                     & ~r_rfi_shadow & ~w_take_sync;

  // Lowest-numbered pending line wins: scan downward so index 0 is written last.
  always_comb begin
    w_irq_cause = 4'd0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (w_pend[i]) w_irq_cause = 4'(8 + i);
  end

  assign w_rfi = rfi_in & w_idle & ~w_take_sync & ~w_take_irq & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cause      <= 4'd0;
      r_mask       <= '0;
      r_rfi_shadow <= 1'b0;
    end else begin
      r_rfi_shadow <= w_rfi;
      if (mask_wen) r_mask <= mask_wdata;
      case (r_state)
        S_IDLE: begin
          if (w_take_sync) begin
            r_state <= S_ENTER;
            r_cause <= illegal_insn ? 4'd1 : 4'd2;
          end else if (w_take_irq) begin
            r_state <= S_ENTER;
            r_cause <= w_irq_cause;
          end
        end
        S_ENTER: r_state <= S_HOLD;
        S_HOLD:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Pulses are decoded from the state register; rst squelches them at once so
  // an aborted sequence never shows trap/ack in the reset cycle.
  assign trap  = (r_state == S_ENTER) & ~rst;
  assign rfi   = w_rfi;
  assign stall = ~w_idle | w_take_sync | w_take_irq;
  assign cause = r_cause;
  assign irq_mask = r_mask;

  for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_ack
    localparam logic [3:0] C_IRQ = 4'(8 + gi);
    assign irq_ack[gi] = trap & (r_cause == C_IRQ);
  end

endmodule
